// File: rtl/nibbler_core_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nibbler_core_p : parametrised Nibbler accumulator CPU core with ROM/RAM     |
// |                  valid handshakes and selectable immediate extension.      |
// | Revision 1.0   : initial release                                           |
// +----------------------------------------------------------------------------+
module nibbler_core_p #(
   parameter int DATA_W   = 4,
   parameter bit IMM_SEXT = 1'b0
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              run_i,
   output logic [11:0]       prog_addr_o,
   input  logic [7:0]        prog_data_i,
   input  logic              prog_valid_i,
   output logic [11:0]       ram_addr_o,
   output logic              ram_we_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   output logic              ram_re_o,
   input  logic [DATA_W-1:0] ram_rdata_i,
   input  logic              ram_rvalid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_strobe_o,
   output logic [DATA_W-1:0] accu_o,
   output logic              c_flag_o,
   output logic              z_flag_o,
   output logic              phase_o,
   output logic [3:0]        instr_o,
   output logic [3:0]        oprnd_o
);

   localparam logic [3:0] c_JC    = 4'h0;
   localparam logic [3:0] c_JNC   = 4'h1;
   localparam logic [3:0] c_CMPI  = 4'h2;
   localparam logic [3:0] c_CMPM  = 4'h3;
   localparam logic [3:0] c_LIT   = 4'h4;
   localparam logic [3:0] c_IN    = 4'h5;
   localparam logic [3:0] c_LD    = 4'h6;
   localparam logic [3:0] c_ST    = 4'h7;
   localparam logic [3:0] c_JZ    = 4'h8;
   localparam logic [3:0] c_JNZ   = 4'h9;
   localparam logic [3:0] c_ADDI  = 4'hA;
   localparam logic [3:0] c_ADDM  = 4'hB;
   localparam logic [3:0] c_JMP   = 4'hC;
   localparam logic [3:0] c_OUT   = 4'hD;
   localparam logic [3:0] c_NANDI = 4'hE;
   localparam logic [3:0] c_NANDM = 4'hF;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_EXEC   = 2'd1,
      ST_LDWAIT = 2'd2
   } state_t;

   state_t            state_q;
   logic [11:0]       pc_q;
   logic [11:0]       ram_addr_q;
   logic [3:0]        instr_q;
   logic [3:0]        oprnd_q;
   logic [DATA_W-1:0] accu_q;
   logic [DATA_W-1:0] out_q;
   logic              c_q;
   logic              z_q;
   logic              we_q;
   logic              re_q;
   logic              strobe_q;

   logic [DATA_W-1:0] accu_d;
   logic              c_d;
   logic              z_d;

   logic [DATA_W-1:0] w_imm;
   logic [DATA_W-1:0] w_b;
   logic [DATA_W:0]   w_sum;
   logic [11:0]       w_a16;
   logic              w_two_byte;
   logic              w_taken;

   generate
      if (DATA_W == 4) begin : g_imm_native
         assign w_imm = oprnd_q;
      end else if (IMM_SEXT) begin : g_imm_sext
         assign w_imm = {{(DATA_W-4){oprnd_q[3]}}, oprnd_q};
      end else begin : g_imm_zext
         assign w_imm = {{(DATA_W-4){1'b0}}, oprnd_q};
      end
   endgenerate

   // byte2 is only present on the ROM bus while EXEC of a 2-byte op
   assign w_a16 = {oprnd_q, prog_data_i};

   always_comb begin
      w_two_byte = 1'b1;
      case (instr_q)
         c_CMPI, c_LIT, c_IN, c_ADDI, c_OUT, c_NANDI: w_two_byte = 1'b0;
         default:                                    w_two_byte = 1'b1;
      endcase
   end

   always_comb begin
      w_taken = 1'b0;
      case (instr_q)
         c_JC:    w_taken = c_q;
         c_JNC:   w_taken = ~c_q;
         c_JZ:    w_taken = z_q;
         c_JNZ:   w_taken = ~z_q;
         c_JMP:   w_taken = 1'b1;
         default: w_taken = 1'b0;
      endcase
   end

   assign w_b   = (state_q == ST_LDWAIT) ? ram_rdata_i :
                  (instr_q == c_IN)      ? in_data_i   : w_imm;
   assign w_sum = {1'b0, accu_q} + {1'b0, w_b};

   always_comb begin
      accu_d = accu_q;
      c_d    = c_q;
      z_d    = z_q;
      case (instr_q)
         c_LIT, c_IN, c_LD: begin
            accu_d = w_b;
            c_d    = 1'b0;
            z_d    = (w_b == '0);
         end
         c_ADDI, c_ADDM: begin
            accu_d = w_sum[DATA_W-1:0];
            c_d    = w_sum[DATA_W];
            z_d    = (w_sum[DATA_W-1:0] == '0);
         end
         c_CMPI, c_CMPM: begin
            c_d = (accu_q < w_b);
            z_d = (accu_q == w_b);
         end
         c_NANDI, c_NANDM: begin
            accu_d = ~(accu_q & w_b);
            c_d    = 1'b0;
            z_d    = ((accu_q & w_b) == '1);
         end
         default: begin
            accu_d = accu_q;
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= ST_FETCH;
         pc_q       <= '0;
         ram_addr_q <= '0;
         instr_q    <= '0;
         oprnd_q    <= '0;
         accu_q     <= '0;
         out_q      <= '0;
         c_q        <= 1'b0;
         z_q        <= 1'b0;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         strobe_q   <= 1'b0;
      end else begin
         we_q     <= 1'b0;
         re_q     <= 1'b0;
         strobe_q <= 1'b0;
         case (state_q)
            ST_FETCH: begin
               if (run_i && prog_valid_i) begin
                  instr_q <= prog_data_i[7:4];
                  oprnd_q <= prog_data_i[3:0];
                  pc_q    <= pc_q + 12'd1;
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (run_i && (prog_valid_i || !w_two_byte)) begin
                  state_q <= ST_FETCH;
                  case (instr_q)
                     c_JC, c_JNC, c_JZ, c_JNZ, c_JMP: begin
                        pc_q <= w_taken ? w_a16 : (pc_q + 12'd1);
                     end
                     c_ST: begin
                        ram_addr_q <= w_a16;
                        we_q       <= 1'b1;
                        pc_q       <= pc_q + 12'd1;
                     end
                     c_CMPM, c_LD, c_ADDM, c_NANDM: begin
                        ram_addr_q <= w_a16;
                        re_q       <= 1'b1;
                        pc_q       <= pc_q + 12'd1;
                        state_q    <= ST_LDWAIT;
                     end
                     c_OUT: begin
                        out_q    <= accu_q;
                        strobe_q <= 1'b1;
                     end
                     default: begin
                        accu_q <= accu_d;
                        c_q    <= c_d;
                        z_q    <= z_d;
                     end
                  endcase
               end
            end
            ST_LDWAIT: begin
               if (ram_rvalid_i) begin
                  accu_q  <= accu_d;
                  c_q     <= c_d;
                  z_q     <= z_d;
                  state_q <= ST_FETCH;
               end
            end
            default: begin
               state_q <= ST_FETCH;
            end
         endcase
      end
   end

   assign prog_addr_o  = pc_q;
   assign ram_addr_o   = ram_addr_q;
   assign ram_we_o     = we_q;
   assign ram_wdata_o  = accu_q;
   assign ram_re_o     = re_q;
   assign out_data_o   = out_q;
   assign out_strobe_o = strobe_q;
   assign accu_o       = accu_q;
   assign c_flag_o     = c_q;
   assign z_flag_o     = z_q;
   assign phase_o      = (state_q != ST_FETCH);
   assign instr_o      = instr_q;
   assign oprnd_o      = oprnd_q;

endmodule
`default_nettype wire
